stream_mux_arb: RTL
===================

# stream_mux_arb

Parametrised N-channel, valid/ready streaming multiplexer with a registered output stage. It is the successor to the 32-bit 2:1 combinational data mux. It adds configurable width and channel count, two selection modes (explicit select and round-robin), packet-boundary locking via `last`, and one pipeline register. It sits between several producer streams and a single consumer on the datapath.

## Interface
**Parameters**
- `WIDTH`, 32: data width per channel.
- `N_CH`, 4: number of input channels, ≥ 2.
- `SEL_W`, `$clog2(N_CH)`: width of the channel index. Derived; not overridden.

**Ports**
- `clk_i`  in  1  clock. Everything is on the rising edge.
- `rst_ni`  in  1  reset. Asynchronous assert, active-low.
- `mode_i`  in  1  selection mode. 0 = explicit select, 1 = round-robin.
- `sel_i`  in  SEL_W  channel index used in explicit mode.
- `data_i`  in  N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- `valid_i`  in  N_CH  per-channel valid.
- `last_i`  in  N_CH  per-channel end-of-packet flag.
- `ready_o`  out  N_CH  per-channel ready.
- `data_o`  out  WIDTH  registered output data.
- `valid_o`  out  1  registered output valid.
- `last_o`  out  1  registered last flag.
- `ch_o`  out  SEL_W  source channel of the current output beat.
- `ready_i`  in  1  downstream ready.

## Operation
**Handshake**
- A transfer occurs on any edge where valid and ready are both high.
- Once `valid_o` is asserted, `data_o`, `last_o` and `ch_o` hold until the downstream accepts the beat.

**Output register**
- `load = (!valid_o || ready_i) && gnt_vld`.
- `ready_o[k] = (!valid_o || ready_i) && gnt_vld && (gnt == k)`. All other bits are 0.
- `ready_o` depends combinationally on `ready_i`. There is no skid buffer.
- On `load`, the register captures the granted channel's data and last flag, sets `ch_o = gnt`, and sets `valid_o = 1`.
- If the output beat is consumed and there is no `load`, `valid_o` goes to 0.

**Arbitration state machine**
- `UNLOCKED` (reset state):
  - Grant is computed each cycle.
  - `mode_i` and `sel_i` are honoured.
  - A transfer with `last = 0` moves to `LOCKED`, storing `lock_ch = gnt`.
  - A transfer with `last = 1` stays in `UNLOCKED`.
- `LOCKED`:
  - `gnt = lock_ch`. `gnt_vld = valid_i[lock_ch]`.
  - `mode_i` and `sel_i` are ignored.
  - A transfer with `last = 1` returns to `UNLOCKED`.

**Grant rules in `UNLOCKED`**
- Explicit mode:
  - `gnt = sel_i`, `gnt_vld = valid_i[sel_i]`.
  - If `sel_i >= N_CH`, then `gnt_vld = 0` and nothing is granted.
- Round-robin mode:
  - Scan channels `ptr, ptr+1, … ptr+N_CH-1`, wrapping modulo N_CH. The first valid channel wins.
  - If no channel is valid, `gnt_vld = 0`.
- Pointer update:
  - On every transfer with `last = 1`, in either mode, `ptr <= (gnt + 1) mod N_CH`.
  - `ptr` wraps from N_CH-1 to 0.

**Boundary conditions**
- A mid-packet mode or select change has no effect until the packet's last beat is transferred.
- A locked channel that drops `valid_i` stalls the mux. No other channel is granted.
- With simultaneous output consume and new load, the register is overwritten the same edge with no bubble.
- A single-beat packet (`last = 1` on the first beat) never enters `LOCKED`.
- `rst_ni` low mid-packet aborts the packet. State returns to `UNLOCKED` with `ptr = 0`.

## Timing
**Reset values**
- While `rst_ni` is low: `valid_o = 0`, `data_o = 0`, `last_o = 0`, `ch_o = 0`, `ptr = 0`, state `UNLOCKED`.
- `ready_o` is forced to all-zeros while `rst_ni` is low.

**Latency and throughput**
- Latency is 1 cycle from an input transfer to `valid_o`.
- Throughput is 1 beat per cycle while `ready_i` is held high.

**Arbitration timing**
- The grant decision uses current-cycle inputs and registered state only.
- `ptr` and `lock_ch` take their new values on the same edge as the transfer that updates them.
- Round-robin fairness: with all channels continuously valid and single-beat packets, channels are served 0, 1, …, N_CH-1, 0, … in consecutive cycles.

## Test plan
Tests use `WIDTH = 32`, `N_CH = 4`.

1. **Reset:** hold `rst_ni = 0` with all `valid_i = 1` → `valid_o = 0`, `ready_o = 4'b0000`, `data_o = 0`. After release in round-robin mode, the first beat has `ch_o = 0`.
2. **Explicit select:** `mode_i = 0`, `sel_i = 2`, `data_i` channel 2 = 32'h1100, `last = 1`, `ready_i = 1` → next cycle `data_o = 32'h1100`, `ch_o = 2`. `sel_i = 5` is not possible at this width; use a separate `N_CH = 3` build with `sel_i = 3` → no grant.
3. **Round-robin fairness:** all four channels valid, channel k data = 32'h0000_0010 + k, `last = 1`, `ready_i = 1` → `ch_o` sequence 0, 1, 2, 3, 0 on consecutive cycles, and `data_o` matches the channel.
4. **Packet lock:** channel 1 sends a 3-beat packet (`last` on beat 3) while channels 0 and 3 stay valid → three beats from `ch_o = 1`, then channel 3 is granted because `ptr = 2`. A `mode_i` or `sel_i` toggle mid-packet has no effect.
5. **Backpressure:** hold `ready_i = 0` for 5 cycles with `valid_o = 1` → `data_o`, `ch_o` and `last_o` are stable and `ready_o = 0`. When `ready_i` rises, the held beat is consumed and a new beat loads on the same edge.
6. **Reset mid-packet:** assert `rst_ni = 0` after beat 1 of a 3-beat packet on channel 2 → outputs return to reset values. After release, round-robin grants channel 0 first.

Source files
------------

// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream mux with a registered output stage.
// Supports explicit-select or round-robin arbitration, and stays locked to one channel until that packet's last beat.
module stream_mux_arb #(
  parameter int WIDTH = 32,
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  mode_i,
  input  logic [SEL_W-1:0]      sel_i,
  input  logic [N_CH*WIDTH-1:0] data_i,
  input  logic [N_CH-1:0]       valid_i,
  input  logic [N_CH-1:0]       last_i,
  output logic [N_CH-1:0]       ready_o,
  output logic [WIDTH-1:0]      data_o,
  output logic                  valid_o,
  output logic                  last_o,
  output logic [SEL_W-1:0]      ch_o,
  input  logic                  ready_i
);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q;
  logic [SEL_W-1:0]  lock_ch_q;
  logic [SEL_W-1:0]  gnt;
  logic              gnt_vld;
  logic              load;
  logic [WIDTH-1:0]  sel_data;
  logic              sel_last;
  logic [SEL_W-1:0]  cand;

  logic [WIDTH-1:0]  data_p1;
  logic              vld_p1;
  logic              last_p1;
  logic [SEL_W-1:0]  ch_p1;

  // Grant uses only current inputs and registered state; the locked channel overrides mode and select.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    if (state_q == LOCKED) begin
      gnt     = lock_ch_q;
      gnt_vld = valid_i[lock_ch_q];
    end else if (!mode_i) begin
      gnt = sel_i;
      if (int'(sel_i) < N_CH) gnt_vld = valid_i[sel_i];
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cand = SEL_W'((int'(ptr_q) + i) % N_CH);
        if (!gnt_vld && valid_i[cand]) begin
          gnt_vld = 1'b1;
          gnt     = cand;
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt == SEL_W'(k)) begin
        sel_data = data_i[k*WIDTH +: WIDTH];
        sel_last = last_i[k];
      end
    end
  end

  assign load = (!vld_p1 || ready_i) && gnt_vld;

  always_comb begin
    ready_o = '0;
    for (int k = 0; k < N_CH; k++) begin
      ready_o[k] = rst_ni && load && (gnt == SEL_W'(k));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      UNLOCKED: if (load && !sel_last) state_d = LOCKED;
      LOCKED:   if (load && sel_last)  state_d = UNLOCKED;
      default:  state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= UNLOCKED;
      ptr_q     <= '0;
      lock_ch_q <= '0;
    end else begin
      state_q <= state_d;
      if (load && state_q == UNLOCKED && !sel_last) lock_ch_q <= gnt;
      if (load && sel_last) ptr_q <= (gnt == SEL_W'(N_CH-1)) ? '0 : gnt + 1'b1;
    end
  end

  // Output stage boundary: p1 register, overwritten in place when consume and load coincide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      ch_p1   <= '0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= sel_data;
      last_p1 <= sel_last;
      ch_p1   <= gnt;
    end else if (ready_i) begin
      vld_p1 <= 1'b0;
    end
  end

  assign data_o  = data_p1;
  assign valid_o = vld_p1;
  assign last_o  = last_p1;
  assign ch_o    = ch_p1;

endmodule
